// File: rtl/bit_shift_checker.sv
// Walking-one receive checker: locks onto a rotate-left one-hot stream, flags and counts mismatches.
// Latency: all outputs registered, one cycle after the sample. Backpressure: none, samples qualified by i_valid only.
// Optional BIT_SHIFT_CHK_STICKY_EN adds o_err_sticky, held from the first error until i_clr or reset.
module bit_shift_checker #(
    parameter int DATA_WIDTH    = 8,
    parameter int LOCK_COUNT    = 4,
    parameter int UNLOCK_COUNT  = 3,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [DATA_WIDTH-1:0]    i_data,
    input  logic                     i_valid,
    input  logic                     i_clr,
    output logic                     o_locked,
    output logic                     o_err,
    output logic [ERR_CNT_WIDTH-1:0] o_err_cnt
`ifdef BIT_SHIFT_CHK_STICKY_EN
    ,
    output logic                     o_err_sticky
`endif
);

    localparam int MCW = $clog2(LOCK_COUNT + 1);
    localparam int XCW = $clog2(UNLOCK_COUNT + 1);
    localparam logic [MCW-1:0] LOCK_TGT   = MCW'(LOCK_COUNT);
    localparam logic [XCW-1:0] UNLOCK_TGT = XCW'(UNLOCK_COUNT);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        LOCKING = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   expected;
    logic [MCW-1:0]          match_cnt;
    logic [XCW-1:0]          miss_cnt;

    logic                    data_onehot;
    logic                    data_match;
    logic                    err_event;
    logic [DATA_WIDTH-1:0]   data_rotl;
    logic [DATA_WIDTH-1:0]   exp_rotl;
    logic [MCW-1:0]          match_nxt;
    logic [XCW-1:0]          miss_nxt;

    // x & (x-1) clears the lowest set bit, so it is zero only for zero or one-hot words
    assign data_onehot = (i_data != '0) && ((i_data & (i_data - DATA_WIDTH'(1))) == '0);
    assign data_match  = (i_data == expected);
    assign data_rotl   = {i_data[DATA_WIDTH-2:0], i_data[DATA_WIDTH-1]};
    assign exp_rotl    = {expected[DATA_WIDTH-2:0], expected[DATA_WIDTH-1]};
    assign match_nxt   = match_cnt + MCW'(1);
    assign miss_nxt    = miss_cnt + XCW'(1);
    assign err_event   = i_valid && (state == LOCKED) && !data_match;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state     <= SEARCH;
            expected  <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            o_locked  <= 1'b0;
            o_err     <= 1'b0;
            o_err_cnt <= '0;
        end else begin
            o_err <= 1'b0;
            if (i_valid) begin
                case (state)
                    SEARCH: begin
                        if (data_onehot) begin
                            expected  <= data_rotl;
                            match_cnt <= MCW'(1);
                            state     <= LOCKING;
                        end
                    end
                    LOCKING: begin
                        if (data_match) begin
                            expected  <= data_rotl;
                            match_cnt <= match_nxt;
                            if (match_nxt == LOCK_TGT) begin
                                state    <= LOCKED;
                                o_locked <= 1'b1;
                                miss_cnt <= '0;
                            end
                        end else if (data_onehot) begin
                            expected  <= data_rotl;
                            match_cnt <= MCW'(1);
                        end else begin
                            state     <= SEARCH;
                            expected  <= '0;
                            match_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        // prediction free-runs; a corrupt word never re-seeds it
                        expected <= exp_rotl;
                        if (data_match) begin
                            miss_cnt <= '0;
                        end else begin
                            o_err <= 1'b1;
                            if (o_err_cnt != '1) begin
                                o_err_cnt <= o_err_cnt + ERR_CNT_WIDTH'(1);
                            end
                            miss_cnt <= miss_nxt;
                            if (miss_nxt == UNLOCK_TGT) begin
                                state     <= SEARCH;
                                o_locked  <= 1'b0;
                                miss_cnt  <= '0;
                                match_cnt <= '0;
                            end
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
            // placed last so a clear overrides a same-cycle increment
            if (i_clr) begin
                o_err_cnt <= '0;
            end
        end
    end

`ifdef BIT_SHIFT_CHK_STICKY_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_err_sticky <= 1'b0;
        end else if (err_event) begin
            o_err_sticky <= 1'b1;
        end else if (i_clr) begin
            o_err_sticky <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_bit_shift_checker.sv
// Bench for bit_shift_checker: directed scenarios plus a randomized stream against a bit-index reference model.
module tb_bit_shift_checker;

    localparam int DW    = 8;
    localparam int LOCKN = 4;
    localparam int UNLN  = 3;
    localparam int ECW   = 5;
    localparam int CMAX  = (1 << ECW) - 1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [DW-1:0]  data = '0;
    logic           valid = 1'b0;
    logic           clr = 1'b0;
    logic           locked;
    logic           err;
    logic [ECW-1:0] err_cnt;
    logic           sticky;

    int n_checks = 0;
    int n_pass   = 0;
    int gpos     = 0;

    // reference model: prediction held as a bit index, lock progress as a run length
    bit m_locked;
    int m_run, m_pos, m_miss, m_cnt;
    bit m_err, m_sticky;

    always #5 clk = ~clk;

    bit_shift_checker #(
        .DATA_WIDTH(DW), .LOCK_COUNT(LOCKN), .UNLOCK_COUNT(UNLN), .ERR_CNT_WIDTH(ECW)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid), .i_clr(clr),
        .o_locked(locked), .o_err(err), .o_err_cnt(err_cnt)
`ifdef BIT_SHIFT_CHK_STICKY_EN
        , .o_err_sticky(sticky)
`endif
    );
`ifndef BIT_SHIFT_CHK_STICKY_EN
    assign sticky = 1'b0;
`endif

    function automatic int bit_index(input logic [DW-1:0] d);
        int idx = 0;
        for (int b = 0; b < DW; b++) if (d[b]) idx = b;
        return idx;
    endfunction

    task automatic model_reset();
        m_locked = 0; m_run = 0; m_pos = 0; m_miss = 0; m_cnt = 0; m_err = 0; m_sticky = 0;
    endtask

    task automatic model_step(input logic [DW-1:0] d, input bit v, input bit c);
        bit onehot;
        onehot = ($countones(d) == 1);
        m_err = 0;
        if (v) begin
            if (!m_locked) begin
                if (onehot) begin
                    if (m_run > 0 && bit_index(d) == m_pos) m_run++;
                    else m_run = 1;
                    m_pos = (bit_index(d) + 1) % DW;
                    if (m_run == LOCKN) begin
                        m_locked = 1; m_miss = 0;
                    end
                end else begin
                    m_run = 0;
                end
            end else begin
                if (d == (DW'(1) << m_pos)) begin
                    m_miss = 0;
                end else begin
                    m_err = 1;
                    if (m_cnt < CMAX) m_cnt++;
                    m_miss++;
                    if (m_miss == UNLN) begin
                        m_locked = 0; m_run = 0; m_miss = 0;
                    end
                end
                m_pos = (m_pos + 1) % DW;
            end
        end
        if (c) m_cnt = 0;
        if (m_err) m_sticky = 1;
        else if (c) m_sticky = 0;
    endtask

    task automatic cycle(input logic [DW-1:0] d, input bit v, input bit c);
        data = d; valid = v; clr = c;
        @(posedge clk);
        model_step(d, v, c);
        #1;
    endtask

    function automatic logic [DW-1:0] good_word();
        logic [DW-1:0] w;
        w = DW'(1) << gpos;
        gpos = (gpos + 1) % DW;
        return w;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; valid = 1'b0; clr = 1'b0; data = $urandom;
        @(posedge clk);
        model_reset();
        gpos = 0;
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (locked !== 1'b0 || err !== 1'b0 || err_cnt !== '0 || sticky !== 1'b0)
            $display("FAIL reset: locked=%b err=%b cnt=%0d sticky=%b, required all 0", locked, err, err_cnt, sticky);
        else n_pass++;
    endtask

    task automatic test_ideal_lock();
        for (int i = 0; i < 20; i++) begin
            cycle(good_word(), 1, 0);
            n_checks++;
            if (locked !== (i >= LOCKN - 1) || err !== 1'b0 || locked !== m_locked)
                $display("FAIL ideal_lock[%0d]: locked=%b err=%b, required locked=%b err=0", i, locked, err, (i >= LOCKN - 1));
            else n_pass++;
        end
        n_checks++;
        if (err_cnt !== '0) $display("FAIL ideal_cnt: cnt=%0d required 0", err_cnt);
        else n_pass++;
    endtask

    task automatic test_single_error();
        for (int i = 0; i < DW && gpos != 4; i++) cycle(good_word(), 1, 0);
        cycle(8'h30, 1, 0);
        gpos = 5;
        n_checks++;
        if (err !== 1'b1 || err_cnt !== ECW'(1) || locked !== 1'b1)
            $display("FAIL single_err: err=%b cnt=%0d locked=%b, required 1/1/1", err, err_cnt, locked);
        else n_pass++;
        cycle(good_word(), 1, 0);
        n_checks++;
        if (err !== 1'b0 || err_cnt !== ECW'(1) || locked !== 1'b1)
            $display("FAIL single_err_after: err=%b cnt=%0d locked=%b, required 0/1/1", err, err_cnt, locked);
        else n_pass++;
    endtask

    task automatic test_unlock_relock();
        for (int i = 0; i < 3; i++) begin
            cycle(8'h00, 1, 0);
            gpos = (gpos + 1) % DW;
            n_checks++;
            if (err !== 1'b1 || err_cnt !== ECW'(2 + i) || locked !== (i < 2))
                $display("FAIL unlock[%0d]: err=%b cnt=%0d locked=%b, required 1/%0d/%b", i, err, err_cnt, locked, 2 + i, (i < 2));
            else n_pass++;
        end
        for (int i = 0; i < LOCKN; i++) begin
            cycle(good_word(), 1, 0);
            n_checks++;
            if (locked !== (i == LOCKN - 1) || err !== 1'b0 || err_cnt !== ECW'(4))
                $display("FAIL relock[%0d]: locked=%b err=%b cnt=%0d, required %b/0/4", i, locked, err, err_cnt, (i == LOCKN - 1));
            else n_pass++;
        end
    endtask

    task automatic test_search_nonhot();
        logic [DW-1:0] seq [6] = '{8'h03, 8'hFF, 8'h40, 8'h80, 8'h01, 8'h02};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(seq[i], 1, 0);
            n_checks++;
            if (locked !== (i == 5) || err !== 1'b0 || err_cnt !== '0)
                $display("FAIL search[%0d]: locked=%b err=%b cnt=%0d, required %b/0/0", i, locked, err, err_cnt, (i == 5));
            else n_pass++;
        end
        gpos = 2;
    endtask

    task automatic test_valid_toggle();
        bit prev;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(good_word(), 1, 0);
            n_checks++;
            if (locked !== (i >= LOCKN - 1) || err !== 1'b0)
                $display("FAIL toggle_v[%0d]: locked=%b err=%b, required %b/0", i, locked, err, (i >= LOCKN - 1));
            else n_pass++;
            prev = locked;
            cycle(DW'($urandom), 0, 0);
            n_checks++;
            if (locked !== prev || err !== 1'b0 || err_cnt !== '0)
                $display("FAIL toggle_idle[%0d]: locked=%b err=%b cnt=%0d, required %b/0/0", i, locked, err, err_cnt, prev);
            else n_pass++;
        end
        cycle(8'h00, 1, 1);
        gpos = (gpos + 1) % DW;
        n_checks++;
        if (err !== 1'b1 || err_cnt !== '0 || locked !== 1'b1)
            $display("FAIL clr_with_err: err=%b cnt=%0d locked=%b, required 1/0/1", err, err_cnt, locked);
        else n_pass++;
`ifdef BIT_SHIFT_CHK_STICKY_EN
        n_checks++;
        if (sticky !== 1'b1) $display("FAIL sticky_set_wins: sticky=%b required 1", sticky);
        else n_pass++;
`endif
    endtask

    task automatic test_reset_midop();
        for (int i = 0; i < 5; i++) begin
            cycle(~good_word(), 1, 0);
            cycle(good_word(), 1, 0);
        end
        n_checks++;
        if (err_cnt !== ECW'(5) || locked !== 1'b1)
            $display("FAIL pre_reset: cnt=%0d locked=%b, required 5/1", err_cnt, locked);
        else n_pass++;
        do_reset();
        n_checks++;
        if (locked !== 1'b0 || err_cnt !== '0 || err !== 1'b0 || sticky !== 1'b0)
            $display("FAIL midop_reset: locked=%b cnt=%0d err=%b sticky=%b, required all 0", locked, err_cnt, err, sticky);
        else n_pass++;
`ifdef BIT_SHIFT_CHK_STICKY_EN
        for (int i = 0; i < LOCKN; i++) cycle(good_word(), 1, 0);
        cycle(~good_word(), 1, 0);
        cycle(good_word(), 1, 0);
        n_checks++;
        if (sticky !== 1'b1 || err !== 1'b0) $display("FAIL sticky_hold: sticky=%b err=%b, required 1/0", sticky, err);
        else n_pass++;
        cycle(good_word(), 1, 1);
        n_checks++;
        if (sticky !== 1'b0 || err_cnt !== '0) $display("FAIL sticky_clr: sticky=%b cnt=%0d, required 0/0", sticky, err_cnt);
        else n_pass++;
`endif
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < LOCKN; i++) cycle(good_word(), 1, 0);
        for (int i = 0; i < CMAX + 6; i++) begin
            cycle(~good_word(), 1, 0);
            cycle(good_word(), 1, 0);
        end
        n_checks++;
        if (err_cnt !== ECW'(CMAX) || locked !== 1'b1)
            $display("FAIL saturation: cnt=%0d locked=%b, required %0d/1", err_cnt, locked, CMAX);
        else n_pass++;
    endtask

    task automatic test_random();
        int errs = 0;
        logic [DW-1:0] d;
        int r;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
                continue;
            end
            r = $urandom_range(0, 99);
            if (r < 75) d = good_word();
            else if (r < 85) d = DW'(1) << $urandom_range(0, DW - 1);
            else d = DW'($urandom);
            cycle(d, ($urandom_range(0, 9) < 8), ($urandom_range(0, 49) == 0));
            if (locked !== m_locked || err !== m_err || err_cnt !== ECW'(m_cnt)
`ifdef BIT_SHIFT_CHK_STICKY_EN
                || sticky !== m_sticky
`endif
            ) begin
                if (errs < 10)
                    $display("FAIL random[%0d]: locked=%b err=%b cnt=%0d sticky=%b, required %b/%b/%0d/%b",
                             i, locked, err, err_cnt, sticky, m_locked, m_err, m_cnt, m_sticky);
                errs++;
            end
        end
        n_checks++;
        if (errs == 0) n_pass++;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_ideal_lock();
        test_single_error();
        test_unlock_relock();
        test_search_nonhot();
        test_valid_toggle();
        test_reset_midop();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
